// File: rtl/tans_recoder_seq_if.sv
// Byte-stream handshakes of the tANS frame sequencer: Huffman bytes in, recoded bytes out.
interface tans_recoder_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_last);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/tans_recoder_seq.sv
// Frame sequencer around the Huffman-to-tANS recoder: serialises input bytes, packs the
// recoder's 0-3 bit outputs into bytes. TANS_SEQ_FINAL_STATE_EN appends the 4-bit final state.
module tans_recoder_seq #(
  parameter int LEN_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             PHI,
  input  logic             RST,
  tans_recoder_seq_if.slave bus,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_bits,
  output logic             busy,
  output logic             done,
  output logic             err_underrun,
  output logic             err_overflow,
  output logic             rc_I_F,
  output logic             rc_i_stream,
  input  logic [1:0]       rc_BTR,
  input  logic [2:0]       rc_o_stream,
  input  logic [3:0]       rc_final_state
);
  localparam int STAGES = 3;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int IW     = $clog2(ACC_W);
`ifdef TANS_SEQ_FINAL_STATE_EN
  localparam int FS_BITS = 4;
`else
  localparam int FS_BITS = 0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, FLUSH} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [1:0][7:0]   buf_q;
  logic              head_q;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [2:0]        bidx_q;
  logic              first_q;
  logic [STAGES-1:0] vld_pipe_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fl_q;
  logic              busy_q, done_q, eund_q, eovf_q;
  logic              ovf;

  logic feeding, have_b, push, bpop, tail, cap, ov, pop, flush_first;
  logic [2:0] an;
  logic [3:0] ab;
  int cnt_i, rem_tot;

  function automatic int pad8(input int x);
    int p;
    p = ((x + 7) / 8) * 8;
    return (p > ACC_W) ? ACC_W : p;
  endfunction

  // Input byte buffer and serialiser
  assign feeding      = (state_q == FEED);
  assign have_b       = (bcnt_q != 2'd0);
  assign bus.in_ready = (state_q == LOAD || feeding) && (bcnt_q != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign tail         = head_q ^ bcnt_q[0];
  // Head byte retires on its last bit, or early when the frame ends mid-byte.
  assign bpop         = feeding && have_b && (bidx_q == 3'd0 || rem_q == LEN_W'(1));
  assign bcnt_d       = bcnt_q + 2'(push) - 2'(bpop);
  assign rc_i_stream  = feeding && have_b && buf_q[head_q][bidx_q];
  assign rc_I_F       = feeding && first_q;

  // Output side of the accumulator (MSB-aligned, earliest bit at ACC_W-1)
  assign cap         = vld_pipe_q[STAGES-1];
  assign flush_first = (state_q == FLUSH) && !fl_q;
  assign cnt_i       = int'(cnt_q);
  assign rem_tot     = fl_q ? cnt_i : pad8(cnt_i + FS_BITS);
  assign ov          = (cnt_i >= 8) || ((state_q == FLUSH) && fl_q && (cnt_i != 0));
  assign pop         = ov && bus.out_ready;
  assign bus.out_valid = ov;
  assign bus.out_data  = acc_q[ACC_W-1 -: 8];
  assign bus.out_last  = (state_q == FLUSH) && ov && (rem_tot <= 8);

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = eund_q;
  assign err_overflow = eovf_q;

`ifndef TANS_SEQ_FINAL_STATE_EN
  logic unused_fs;
  assign unused_fs = ^rc_final_state;
`else
  logic [3:0] fs_q;
`endif

  // Pop first, then append at the freed position; bits past ACC_W are dropped.
  always_comb begin
    int n;
    logic [IW-1:0] idx;
    acc_d = acc_q;
    n     = cnt_i;
    ovf   = 1'b0;
    an    = 3'd0;
    ab    = 4'd0;
    idx   = '0;
    if (pop) begin
      acc_d = acc_q << 8;
      n     = (n > 8) ? n - 8 : 0;
    end
    if (cap) begin
      an = {1'b0, rc_BTR};
      case (rc_BTR)
        2'd1:    ab = {rc_o_stream[0], 3'b000};
        2'd2:    ab = {rc_o_stream[1:0], 2'b00};
        2'd3:    ab = {rc_o_stream, 1'b0};
        default: ab = 4'd0;
      endcase
    end
`ifdef TANS_SEQ_FINAL_STATE_EN
    else if (flush_first) begin
      an = 3'd4;
      ab = fs_q;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < int'(an)) begin
        if (n < ACC_W) begin
          idx        = IW'(ACC_W - 1 - n);
          acc_d[idx] = ab[3];
          n          = n + 1;
        end else begin
          ovf = 1'b1;
        end
        ab = ab << 1;
      end
    end
    if (flush_first) n = pad8(n);
    cnt_d = CNT_W'(n);
  end

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      buf_q      <= '0;
      head_q     <= 1'b0;
      bcnt_q     <= 2'd0;
      bidx_q     <= 3'd7;
      first_q    <= 1'b0;
      vld_pipe_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      fl_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eund_q     <= 1'b0;
      eovf_q     <= 1'b0;
`ifdef TANS_SEQ_FINAL_STATE_EN
      fs_q       <= 4'd0;
`endif
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], feeding};
      bcnt_q     <= bcnt_d;
      done_q     <= 1'b0;
`ifdef TANS_SEQ_FINAL_STATE_EN
      if (cap) fs_q <= rc_final_state;
`endif
      if (push) buf_q[tail] <= bus.in_data;
      if (bpop) begin
        head_q <= ~head_q;
        bidx_q <= 3'd7;
      end else if (feeding && have_b) begin
        bidx_q <= bidx_q - 3'd1;
      end
      if (ovf) eovf_q <= 1'b1;
      // An empty buffer does not stall the recoder: feed a 0 and flag it.
      if (feeding && !have_b) eund_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          eund_q  <= 1'b0;
          eovf_q  <= 1'b0;
          busy_q  <= 1'b1;
          first_q <= 1'b1;
          rem_q   <= frame_bits;
          head_q  <= 1'b0;
          bcnt_q  <= 2'd0;
          bidx_q  <= 3'd7;
          if (frame_bits == '0) begin
            state_q <= FLUSH;
            fl_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD;
            fl_q    <= 1'b0;
          end
        end
        LOAD: if (bcnt_d != 2'd0) state_q <= FEED;
        FEED: begin
          first_q <= 1'b0;
          rem_q   <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_q <= DRAIN;
        end
        DRAIN: if (vld_pipe_q[STAGES-2:0] == '0) state_q <= FLUSH;
        FLUSH: begin
          if (done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            fl_q   <= 1'b1;
            done_q <= (cnt_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tans_recoder_seq.sv
// Directed bench for tans_recoder_seq: constant recoder outputs, hand-computed byte streams.
module tb_tans_recoder_seq;
`ifdef TANS_SEQ_FINAL_STATE_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic PHI = 1'b0;
  logic RST = 1'b0;
  always #5 PHI = ~PHI;

  tans_recoder_seq_if ifc();
  logic        start;
  logic [15:0] frame_bits;
  logic        busy, done, err_underrun, err_overflow, rc_I_F, rc_i_stream;
  logic [1:0]  rc_BTR;
  logic [2:0]  rc_o_stream;
  logic [3:0]  rc_final_state;

  tans_recoder_seq #(.LEN_W(16), .ACC_W(16)) dut (
    .PHI(PHI), .RST(RST), .bus(ifc),
    .start(start), .frame_bits(frame_bits),
    .busy(busy), .done(done), .err_underrun(err_underrun), .err_overflow(err_overflow),
    .rc_I_F(rc_I_F), .rc_i_stream(rc_i_stream),
    .rc_BTR(rc_BTR), .rc_o_stream(rc_o_stream), .rc_final_state(rc_final_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: output bytes and done pulses, sampled mid-cycle
  logic [7:0] ob_d[$];
  logic       ob_l[$];
  int done_cnt = 0;
  int ov_seen  = 0;
  always @(negedge PHI) begin
    if (ifc.out_valid && ifc.out_ready) begin
      ob_d.push_back(ifc.out_data);
      ob_l.push_back(ifc.out_last);
    end
    if (ifc.out_valid) ov_seen++;
    if (done) done_cnt++;
  end

  // Byte source; flush_gen bumps discard anything not yet consumed
  logic [7:0] src_q[$];
  int flush_gen = 0;
  initial begin
    int rd;
    int gen;
    logic hs;
    rd = 0;
    gen = 0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    forever begin
      @(negedge PHI);
      hs = ifc.in_valid && ifc.in_ready;
      @(posedge PHI);
      #1;
      if (hs) rd++;
      if (gen != flush_gen) begin
        gen = flush_gen;
        rd  = src_q.size();
      end
      ifc.in_valid = (rd < src_q.size());
      ifc.in_data  = (rd < src_q.size()) ? src_q[rd] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge PHI);
    #1;
  endtask

  task automatic go(input logic [15:0] n);
    start = 1'b1;
    frame_bits = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk({tag, "_done"}, 32'(done_cnt != d0), 1);
    tick();
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input int ne);
    logic [7:0] e;
    chk({tag, "_nbytes"}, 32'(ob_d.size() - base), 32'(ne));
    for (int i = 0; i < ne && base + i < ob_d.size(); i++) begin
      e = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      chk({tag, "_byte"}, 32'(ob_d[base + i]), 32'(e));
      chk({tag, "_last"}, 32'(ob_l[base + i]), 32'(i == ne - 1));
    end
  endtask

  // Waits for the init flag, then records nb consecutive fed bits and init flags.
  task automatic grab(input string tag, input int nb, output logic [15:0] seq,
                      output logic [15:0] ifs);
    int k;
    k = 0;
    seq = '0;
    ifs = '0;
    while (!rc_I_F && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_if_seen"}, 32'(rc_I_F), 1);
    for (int i = 0; i < nb; i++) begin
      seq = {seq[14:0], rc_i_stream};
      ifs = {ifs[14:0], rc_I_F};
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int d0;
    int ovs;
    logic [15:0] seq, ifs;
    start = 1'b0;
    frame_bits = '0;
    rc_BTR = 2'd0;
    rc_o_stream = 3'd0;
    rc_final_state = 4'd0;
    ifc.out_ready = 1'b0;
    #1 RST = 1'b1;
    repeat (3) tick();
    chk("rst_outs", 32'({busy, done, err_underrun, err_overflow, rc_I_F, rc_i_stream,
                         ifc.in_ready, ifc.out_valid, ifc.out_last, ifc.out_data}), 0);
    RST = 1'b0;
    tick();

    // 1: basic frame, eight 1-bit captures of '1'
    rc_BTR = 2'd1; rc_o_stream = 3'b001; rc_final_state = 4'b1000; ifc.out_ready = 1'b1;
    src_q.push_back(8'hA5);
    base = ob_d.size();
    go(16'd8);
    chk("t1_busy", 32'(busy), 1);
    wait_done("t1", 100);
    chk_bytes("t1", base, 8'hFF, 8'h80, 8'h00, FS ? 2 : 1);
    chk("t1_errs", 32'({err_underrun, err_overflow}), 0);

    // 2: init flag and serial order, no recoder output
    rc_BTR = 2'd0; rc_final_state = 4'b0110;
    src_q.push_back(8'hC3);
    src_q.push_back(8'h80);
    base = ob_d.size();
    go(16'd10);
    grab("t2", 10, seq, ifs);
    chk("t2_stream", 32'(seq), 32'h30E);
    chk("t2_initflag", 32'(ifs), 32'h200);
    chk("t2_if_after", 32'(rc_I_F), 0);
    wait_done("t2", 100);
    chk_bytes("t2", base, 8'h60, 8'h00, 8'h00, FS ? 1 : 0);

    // 3: underrun, one byte for a 16-bit frame
    rc_BTR = 2'd1; rc_o_stream = 3'b001; rc_final_state = 4'b1000;
    src_q.push_back(8'hFF);
    base = ob_d.size();
    go(16'd16);
    grab("t3", 16, seq, ifs);
    chk("t3_stream", 32'(seq), 32'hFF00);
    wait_done("t3", 100);
    chk("t3_underrun", 32'(err_underrun), 1);
    chk("t3_overflow", 32'(err_overflow), 0);
    chk_bytes("t3", base, 8'hFF, 8'hFF, 8'h80, FS ? 3 : 2);

    // 4: overflow, 24 bits into a 16-bit accumulator with the output stalled
    ifc.out_ready = 1'b0; rc_BTR = 2'd3; rc_o_stream = 3'b101;
    src_q.push_back(8'h00);
    base = ob_d.size();
    go(16'd8);
    repeat (20) tick();
    chk("t4_overflow", 32'(err_overflow), 1);
    chk("t4_hold", 32'({ifc.out_valid, ifc.out_last, ifc.out_data}), 32'h2B6);
    tick();
    chk("t4_hold2", 32'({ifc.out_valid, ifc.out_last, ifc.out_data}), 32'h2B6);
    ifc.out_ready = 1'b1;
    wait_done("t4", 100);
    chk_bytes("t4", base, 8'hB6, 8'hDB, 8'h00, 2);
    chk("t4_ovf_sticky", 32'(err_overflow), 1);

    // 5: zero-length frame; a start while busy is ignored
    rc_BTR = 2'd1; rc_o_stream = 3'b001;
    base = ob_d.size();
    ovs = ov_seen;
    go(16'd0);
    chk("t5_done", 32'({done, busy}), 32'h3);
    chk("t5_errclr", 32'({err_underrun, err_overflow}), 0);
    start = 1'b1; frame_bits = 16'd8;
    tick();
    start = 1'b0;
    chk("t5_after", 32'({done, busy}), 0);
    tick();
    chk("t5_ignored", 32'({busy, ifc.in_ready}), 0);
    chk("t5_noout", 32'(ov_seen - ovs), 0);
    chk("t5_nbytes", 32'(ob_d.size() - base), 0);

    // 6: reset at bit 5 of a frame, then a clean frame
    rc_final_state = 4'b1000;
    src_q.push_back(8'hFF);
    src_q.push_back(8'hFF);
    d0 = done_cnt;
    go(16'd16);
    grab("t6", 4, seq, ifs);
    RST = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({busy, done, err_underrun, err_overflow, rc_I_F, rc_i_stream,
                            ifc.in_ready, ifc.out_valid, ifc.out_last, ifc.out_data}), 0);
    tick();
    tick();
    RST = 1'b0;
    flush_gen++;
    tick();
    tick();
    chk("t6_nodone", 32'(done_cnt - d0), 0);
    src_q.push_back(8'hA5);
    base = ob_d.size();
    go(16'd8);
    wait_done("t6", 100);
    chk_bytes("t6", base, 8'hFF, 8'h80, 8'h00, FS ? 2 : 1);
    chk("t6_errs", 32'({err_underrun, err_overflow}), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tans_recoder_seq.md
# tans_recoder_seq

Frame sequencer for the Huffman-to-tANS recoder datapath. It does four things:
- accepts Huffman-coded bits as bytes over a valid/ready port;
- serialises them into the recoder one bit per clock, asserting the recoder's frame-init flag on the first bit;
- captures the recoder's variable-width output (0–3 bits per cycle) three cycles later and packs it MSB-first into bytes on a valid/ready output port;
- optionally appends the 4-bit final tANS state.

The recoder has no clock enable, so a frame must stream without gaps; the sequencer absorbs output backpressure in an accumulator and reports underrun and overflow.

## Interface
- `LEN_W`, default 16: width of the frame bit-count.
- `ACC_W`, default 32: output accumulator depth in bits; legal range 16–64.
- `PHI` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `frame_bits` in `LEN_W`: number of code bits in the frame; latched on `start`.
- `in_data` in 8: code bits; bit 7 is serialised first.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `out_data` out 8: packed recoded bits; bit 7 is the earliest bit.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_last` out 1: qualifies the final byte of the frame.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.
- `err_underrun` out 1: sticky; cleared by `start`.
- `err_overflow` out 1: sticky; cleared by `start`.
- `rc_I_F` out 1: connects to recoder `I_F`.
- `rc_i_stream` out 1: connects to recoder `i_stream`.
- `rc_BTR` in 2: recoder `BTR`.
- `rc_o_stream` in 3: recoder `o_stream`.
- `rc_final_state` in 4: recoder `final_state`.

## Operation
- **Input buffer:** 2-entry byte buffer. `in_ready` is high while at least one entry is free and state is LOAD or FEED.
- **IDLE → LOAD:** on `start` with `frame_bits != 0`. Latches the bit count and clears the error flags.
- **IDLE → FLUSH:** on `start` with `frame_bits == 0`. No bits are fed.
- **LOAD:** waits for the first input byte. `rc_I_F` and `rc_i_stream` are held at 0.
- **LOAD → FEED:** as soon as the buffer is non-empty.
- **FEED:**
  - Drives one bit per cycle on `rc_i_stream`, MSB of the head byte first, and decrements the remaining count.
  - `rc_I_F` is 1 only on the frame's first fed bit.
  - When the head byte is exhausted, the next entry is used in the next cycle with no gap.
  - If the buffer is empty while bits remain: drive 0, count the bit as fed, and set `err_underrun`.
  - Moves to DRAIN after the last bit is fed. Unused low bits of the last byte are discarded.
- **Capture window:** a 3-deep shift register delays a fed-bit flag. When the delayed flag is 1, `rc_BTR` bits of `rc_o_stream` are appended to the accumulator: `rc_o_stream[BTR-1]` first, down to `[0]`. `BTR == 0` appends nothing.
- **DRAIN:** lasts until the delay register is empty, exactly 3 cycles. Transitions to FLUSH.
- **FLUSH:**
  - With the final-state feature (see Configuration), appends the 4-bit final state (the value captured on the last capture-window cycle).
  - Zero-pads to a byte boundary.
  - Waits until the accumulator is empty, then goes to IDLE and pulses `done`.
- **Output:**
  - `out_valid` is high when the accumulator holds ≥ 8 bits, or when in FLUSH with padding applied and > 0 bits held.
  - `out_last` is high on the byte that empties the accumulator in FLUSH.
- **Overflow:** if an append would exceed `ACC_W`, the excess bits are dropped and `err_overflow` is set.
- **Simultaneous events:** an append and a byte pop in the same cycle are both applied. The pop happens first, so its freed space is available to the append.
- **Ignored input:** `start` while `busy` is ignored.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, the accumulator and buffer are empty.
- **Reset mid-frame:** aborts immediately; no `done` is produced.
- `busy` rises the cycle after `start` is accepted and falls with the `done` pulse.
- **Latency:** a bit fed in cycle N is captured at the end of cycle N+3. The first output byte can be valid no earlier than N+4.
- A frame with `frame_bits == 0` pulses `done` 1 cycle after `start`, with no output bytes.
- **Output handshake:** `out_data`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`.

## Configuration
- Macro: `TANS_SEQ_FINAL_STATE_EN`.
- **Defined:** FLUSH appends `rc_final_state[3:0]` MSB-first before padding.
- **Undefined:** no state is appended, and the stream ends with the last captured bits plus padding.

## Test plan
1. **Basic frame:** `frame_bits=8`, `in_data=8'hA5`, model BTR=1 / o_stream=1 every capture, `out_ready=1` → 8 ones captured, then state 4'b1000 (macro defined) → bytes `8'hFF`, `8'h80` with `out_last` on byte 2; `done` pulses 3 cycles after the last capture plus pop cycles.
2. **Init flag and serial order:** `frame_bits=10`, bytes `8'hC3`, `8'h80` → `rc_I_F` is high only on cycle 1; `rc_i_stream` sequence is 1,1,0,0,0,0,1,1,1,0 with no gaps.
3. **Underrun:** `frame_bits=16`, only one byte supplied → the second 8 bits are driven 0, `err_underrun=1`, and the frame still completes with `done`.
4. **Overflow:** `ACC_W=16`, `out_ready=0`, BTR=3 every cycle for 8 bits → `err_overflow=1`, and the accumulator holds exactly 16 bits.
5. **Zero-length frame and busy:** `frame_bits=0` → `done` the next cycle, no `out_valid`. A `start` asserted while `busy` has no effect.
6. **Reset mid-FEED:** assert `RST` at bit 5 → all outputs are 0 at once; a new frame after reset runs cleanly with error flags at 0.
